// File: rtl/cv32e40p_obi_mem_responder.sv
// Purpose: OBI-style bench memory; byte-enabled writes, in-order read responses with per-request delay.
// Latency: combinational gnt_o; response max(T+max(d,1), previous response+1), minimum 1 cycle after grant.
// Backpressure: gnt_o drops when the response queue is full (unless the head retires) or stall_gnt_i is set; rvalid_o has none.
//
// Ports:
//   clk_i, rst_i          rising-edge clock, synchronous active-high reset
//   req_i, gnt_o          request / grant handshake
//   addr_i, we_i, be_i,   byte address (word index from bits [log2(MEM_WORDS)+1:2]),
//   wdata_i               write flag, byte enables, write data
//   rvalid_o, rdata_o     registered response (rdata_o is 0 for writes, holds between responses)
//   stall_gnt_i           suppresses grant
//   rsp_delay_i           response delay for the request granted this cycle
//   outstanding_o         granted-but-not-retired entry count
module cv32e40p_obi_mem_responder #(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned DELAY_WIDTH     = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             req_i,
    output logic                             gnt_o,
    input  logic [31:0]                      addr_i,
    input  logic                             we_i,
    input  logic [3:0]                       be_i,
    input  logic [31:0]                      wdata_i,
    output logic                             rvalid_o,
    output logic [31:0]                      rdata_o,
    input  logic                             stall_gnt_i,
    input  logic [DELAY_WIDTH-1:0]           rsp_delay_i,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0]            rdata;
        logic [DELAY_WIDTH-1:0] cnt;
    } rsp_ent_t;

    // Word array: no reset, contents survive rst_i.
    logic [31:0]                mem_q [MEM_WORDS];

    // Response queue: circular buffer with a valid bit per slot so every
    // live entry can count down independently of its position.
    rsp_ent_t                   q_dat [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] q_vld;
    logic [PTR_W-1:0]           rd_ptr_q;
    logic [PTR_W-1:0]           wr_ptr_q;
    logic [OCC_W-1:0]           occ_q;

    logic [IDX_W-1:0]           mem_idx;
    logic                       unused_addr_bits;

    rsp_ent_t                   head_ent;
    logic                       head_pop;
    logic                       full;
    logic                       hs;
    logic [DELAY_WIDTH-1:0]     in_cnt;
    logic [31:0]                in_rdata;
    logic                       bypass;
    logic                       push;
    rsp_ent_t                   push_ent;
    logic                       rsp_vld;
    logic [31:0]                rsp_dat;

    // Upper address bits wrap onto the array; byte offset is ignored.
    assign mem_idx          = addr_i[IDX_W+1:2];
    assign unused_addr_bits = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

    always_comb begin
        head_ent = q_dat[rd_ptr_q];
        // Only stored entries are considered here so that the full/grant
        // path never depends on the incoming request.
        head_pop = q_vld[rd_ptr_q] && (head_ent.cnt == '0);
        full     = (occ_q == OCC_W'(MAX_OUTSTANDING)) && !head_pop;
        gnt_o    = req_i && !stall_gnt_i && !full && !rst_i;
        hs       = req_i && gnt_o;

        // Remaining wait expressed as cycles beyond the grant cycle; d=0 acts as d=1.
        in_cnt   = (rsp_delay_i == '0) ? '0 : rsp_delay_i - DELAY_WIDTH'(1);
        in_rdata = we_i ? 32'h0 : mem_q[mem_idx];

        // The incoming request is treated as a virtual tail entry during its
        // grant cycle: it counts down once before being stored, and if the
        // queue is empty and its count is already zero it retires immediately,
        // giving the one-cycle minimum latency.
        bypass   = hs && (occ_q == '0) && (in_cnt == '0);
        push     = hs && !bypass;

        push_ent.rdata = in_rdata;
        push_ent.cnt   = (in_cnt == '0) ? '0 : in_cnt - DELAY_WIDTH'(1);

        rsp_vld  = head_pop || bypass;
        rsp_dat  = head_pop ? head_ent.rdata : in_rdata;
    end

    // Byte-lane write; only a granted write touches the array.
    always_ff @(posedge clk_i) begin
        if (hs && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Entry payload and countdown. A push into the slot being popped in the
    // same cycle overrides the countdown by coming later.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (q_vld[i] && (q_dat[i].cnt != '0)) begin
                q_dat[i].cnt <= q_dat[i].cnt - DELAY_WIDTH'(1);
            end
        end
        if (push) begin
            q_dat[wr_ptr_q] <= push_ent;
        end
    end

    // Queue control and registered response outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_vld    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            rvalid_o <= 1'b0;
            rdata_o  <= 32'h0;
        end else begin
            // Pop before push so a full queue recycling its head slot ends valid.
            if (head_pop) begin
                q_vld[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
            end
            if (push) begin
                q_vld[wr_ptr_q] <= 1'b1;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            case ({push, head_pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
            rvalid_o <= rsp_vld;
            if (rsp_vld) begin
                rdata_o <= rsp_dat;
            end
        end
    end

    assign outstanding_o = occ_q;

endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
// Purpose: self-checking bench for cv32e40p_obi_mem_responder against a response-time/memory model.
// Latency: model predicts each response cycle as max(T+max(d,1), previous+1).
// Backpressure: model predicts grant from pending-entry count and head retirement.
module tb_cv32e40p_obi_mem_responder;

    localparam int MAXO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        stall_gnt_i;
    logic [3:0]  rsp_delay_i;
    logic [2:0]  outstanding_o;

    always #5 clk_i = ~clk_i;

    cv32e40p_obi_mem_responder #(
        .MEM_WORDS      (1024),
        .MAX_OUTSTANDING(MAXO),
        .DELAY_WIDTH    (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .be_i         (be_i),
        .wdata_i      (wdata_i),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .stall_gnt_i  (stall_gnt_i),
        .rsp_delay_i  (rsp_delay_i),
        .outstanding_o(outstanding_o)
    );

    // Reference model: every granted request becomes one expected response
    // with an absolute cycle number.
    typedef struct {
        int          gcyc;
        int          rc;
        logic [31:0] data;
    } exp_rsp_t;

    exp_rsp_t    pend[$];
    logic [31:0] mem_m [1024];
    int          cyc       = 0;
    int          last_rc   = 0;
    int          n_checks  = 0;
    int          n_errors  = 0;
    logic [31:0] rdata_hold = 32'h0;

    logic        obs_gnt;
    logic        obs_rvalid;
    logic [31:0] obs_rdata;
    logic [2:0]  obs_occ;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check all outputs mid-cycle, advance model.
    task automatic step(input logic rst, input logic req, input logic we, input logic stall,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [3:0] dly);
        int          occ_exp;
        bit          pop_now;
        bit          exp_gnt;
        bit          exp_rv;
        int          dd;
        int          rc;
        logic [9:0]  idx;
        logic [31:0] data;
        rst_i       = rst;
        req_i       = req;
        we_i        = we;
        stall_gnt_i = stall;
        addr_i      = addr;
        wdata_i     = wdata;
        be_i        = be;
        rsp_delay_i = dly;
        @(negedge clk_i);
        obs_gnt    = gnt_o;
        obs_rvalid = rvalid_o;
        obs_rdata  = rdata_o;
        obs_occ    = outstanding_o;

        occ_exp = 0;
        pop_now = 0;
        foreach (pend[i]) begin
            if (pend[i].gcyc < cyc && pend[i].rc > cyc)  occ_exp++;
            if (pend[i].gcyc < cyc && pend[i].rc == cyc + 1) pop_now = 1;
        end
        exp_gnt = !rst && req && !stall && !(occ_exp == MAXO && !pop_now);
        chk_eq("gnt", 32'(obs_gnt), 32'(exp_gnt));

        if (!rst) begin
            exp_rv = (pend.size() > 0) && (pend[0].rc == cyc);
            if (exp_rv) begin
                rdata_hold = pend[0].data;
                void'(pend.pop_front());
            end
            chk_eq("rvalid", 32'(obs_rvalid), 32'(exp_rv));
            chk_eq("rdata", obs_rdata, rdata_hold);
            chk_eq("outstanding", 32'(obs_occ), 32'(occ_exp));
        end

        if (exp_gnt) begin
            idx = addr[11:2];
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
                end
                data = 32'h0;
            end else begin
                data = mem_m[idx];
            end
            dd = (dly == 4'd0) ? 1 : int'(dly);
            rc = cyc + dd;
            if (rc <= last_rc) rc = last_rc + 1;
            last_rc = rc;
            pend.push_back('{gcyc: cyc, rc: rc, data: data});
        end

        @(posedge clk_i);
        #1;
        if (rst) begin
            pend.delete();
            rdata_hold = 32'h0;
            last_rc    = cyc;
        end
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be, input logic [3:0] dly);
        step(1'b0, 1'b1, 1'b1, 1'b0, addr, data, be, dly);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [3:0] dly);
        step(1'b0, 1'b1, 1'b0, 1'b0, addr, 32'h0, 4'h0, dly);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (pend.size() > 0 && guard < 100) begin
            idle();
            guard++;
        end
        if (pend.size() > 0) chk_eq("drain_timeout", 32'(pend.size()), 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        int          r;

        // Reset, including a request during reset that must not be granted.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h55555555, 4'hF, 4'h0);
        idle();
        chk_eq("reset_rvalid", 32'(obs_rvalid), 32'h0);
        chk_eq("reset_occ", 32'(obs_occ), 32'h0);

        // Initialise the region used by random traffic.
        for (int i = 0; i < 64; i++) wr(32'(i * 4), $urandom, 4'hF, 4'h0);
        idle();

        // Write then read 0x100.
        wr(32'h100, 32'hDEADBEEF, 4'hF, 4'h0);
        chk_eq("wr_gnt", 32'(obs_gnt), 32'h1);
        rd(32'h100, 4'h0);
        chk_eq("rd_gnt", 32'(obs_gnt), 32'h1);
        chk_eq("wr_rsp_vld", 32'(obs_rvalid), 32'h1);
        chk_eq("wr_rsp_dat", obs_rdata, 32'h0);
        idle();
        chk_eq("rd_rsp_vld", 32'(obs_rvalid), 32'h1);
        chk_eq("rd_rsp_dat", obs_rdata, 32'hDEADBEEF);

        // Byte-enabled overwrite.
        wr(32'h100, 32'h11223344, 4'h5, 4'h0);
        rd(32'h100, 4'h0);
        idle();
        chk_eq("be_dat", obs_rdata, 32'hDE22BE44);

        // Back-to-back reads with a slow first response.
        wr(32'h0, 32'd1, 4'hF, 4'h0);
        wr(32'h4, 32'd2, 4'hF, 4'h0);
        wr(32'h8, 32'd3, 4'hF, 4'h0);
        wr(32'hC, 32'd4, 4'hF, 4'h0);
        idle();
        rd(32'h0, 4'd5);
        rd(32'h4, 4'd1);
        rd(32'h8, 4'd1);
        rd(32'hC, 4'd1);
        for (int k = 1; k <= 6; k++) begin
            idle();
            chk_eq("b2b_vld", 32'(obs_rvalid), 32'((k >= 2 && k <= 5) ? 1 : 0));
            if (k >= 2 && k <= 5) chk_eq("b2b_dat", obs_rdata, 32'(k - 1));
        end

        // Fill the queue with slow reads while holding req high.
        for (int s = 0; s < 20; s++) begin
            rd(32'h10, 4'd15);
            if (s == 4) begin
                chk_eq("fill_gnt", 32'(obs_gnt), 32'h0);
                chk_eq("fill_occ", 32'(obs_occ), 32'h4);
            end
            if (s == 14) begin
                chk_eq("pop_gnt", 32'(obs_gnt), 32'h1);
                chk_eq("pop_occ", 32'(obs_occ), 32'h4);
            end
        end
        drain();
        idle();

        // Grant stall: the stalled write must not land.
        wr(32'h200, 32'h12345678, 4'hF, 4'h0);
        for (int s = 0; s < 3; s++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 4'hF, 4'h0);
            chk_eq("stall_gnt", 32'(obs_gnt), 32'h0);
        end
        rd(32'h200, 4'h0);
        chk_eq("unstall_gnt", 32'(obs_gnt), 32'h1);
        idle();
        chk_eq("stall_nowrite", obs_rdata, 32'h12345678);

        // Reset with three reads pending; memory survives.
        rd(32'h0, 4'd10);
        rd(32'h4, 4'd10);
        rd(32'h8, 4'd10);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
        for (int k = 0; k < 12; k++) begin
            idle();
            chk_eq("rst_drop_vld", 32'(obs_rvalid), 32'h0);
        end
        rd(32'h100, 4'h0);
        idle();
        chk_eq("rst_keep_mem", obs_rdata, 32'hDE22BE44);

        // Randomized traffic, addresses wrap via random upper bits.
        for (int n = 0; n < 1500; n++) begin
            a       = $urandom;
            a[11:2] = 10'($urandom_range(0, 63));
            r       = int'($urandom_range(0, 99));
            if ($urandom_range(0, 299) == 0) begin
                step(1'b1, 1'b1, 1'b0, 1'b0, a, $urandom, 4'($urandom), 4'($urandom));
            end else begin
                step(1'b0, (r < 70), 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 15),
                     a, $urandom, 4'($urandom),
                     ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2)));
            end
        end
        drain();
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
